// File: rtl/acc_block_feeder.sv
// acc_block_feeder: buffers 2x2 FP32 partial-product blocks and issues them to the accumulator
// over start/done, then hands the accumulated tile downstream. ACC_FEEDER_PERF_EN adds perf counters.
module acc_block_feeder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned K_W   = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    in_a11,
   input  logic [31:0]    in_a12,
   input  logic [31:0]    in_a21,
   input  logic [31:0]    in_a22,
   input  logic [K_W-1:0] k_count,
   output logic [31:0]    acc_a11,
   output logic [31:0]    acc_a12,
   output logic [31:0]    acc_a21,
   output logic [31:0]    acc_a22,
   output logic           acc_start,
   output logic           acc_clear,
   input  logic           acc_done,
   input  logic [31:0]    acc_o11,
   input  logic [31:0]    acc_o12,
   input  logic [31:0]    acc_o21,
   input  logic [31:0]    acc_o22,
   output logic           tile_valid,
   output logic [31:0]    tile_c11,
   output logic [31:0]    tile_c12,
   output logic [31:0]    tile_c21,
   output logic [31:0]    tile_c22,
   input  logic           tile_ack
`ifdef ACC_FEEDER_PERF_EN
   ,
   output logic [31:0]    perf_wait_cyc,
   output logic [15:0]    perf_tiles
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned BLK_W = 128;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CLEAR,
      TILE
   } state_t;

   state_t            state;
   logic [BLK_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   logic              push_c;
   logic              pop_c;
   logic [K_W-1:0]    blk_cnt;
   logic [K_W-1:0]    k_lat;
   logic [BLK_W-1:0]  acc_blk;
   logic [BLK_W-1:0]  tile_blk;
   logic [BLK_W-1:0]  in_blk;
   logic [BLK_W-1:0]  sum_blk;

   assign in_blk  = {in_a11, in_a12, in_a21, in_a22};
   assign sum_blk = {acc_o11, acc_o12, acc_o21, acc_o22};

   assign acc_a11  = acc_blk[127:96];
   assign acc_a12  = acc_blk[95:64];
   assign acc_a21  = acc_blk[63:32];
   assign acc_a22  = acc_blk[31:0];
   assign tile_c11 = tile_blk[127:96];
   assign tile_c12 = tile_blk[95:64];
   assign tile_c21 = tile_blk[63:32];
   assign tile_c22 = tile_blk[31:0];

   // Pop only happens from IDLE, so a pending tile naturally blocks issue while the FIFO keeps filling.
   always_comb begin
      push_c    = in_valid & in_ready;
      pop_c     = (state == IDLE) && (count != '0);
      count_nxt = count + CNT_W'(push_c) - CNT_W'(pop_c);
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= in_blk;
      end
   end

   // FIFO pointers and occupancy; in_ready is registered from next-cycle occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b1;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count    <= count_nxt;
         in_ready <= (count_nxt != CNT_W'(DEPTH));
      end
   end

   // Issue/accumulate/tile control with registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         blk_cnt    <= '0;
         k_lat      <= K_W'(1);
         acc_blk    <= '0;
         tile_blk   <= '0;
         acc_start  <= 1'b0;
         acc_clear  <= 1'b0;
         tile_valid <= 1'b0;
      end else begin
         acc_start <= 1'b0;
         acc_clear <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop_c) begin
                  acc_blk   <= mem[rd_ptr];
                  acc_start <= 1'b1;
                  state     <= ISSUE;
                  if (blk_cnt == '0) begin
                     k_lat <= (k_count == '0) ? K_W'(1) : k_count;
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (acc_done) begin
                  if (blk_cnt == k_lat - K_W'(1)) begin
                     tile_blk  <= sum_blk;
                     acc_clear <= 1'b1;
                     state     <= CLEAR;
                  end else begin
                     blk_cnt <= blk_cnt + K_W'(1);
                     state   <= IDLE;
                  end
               end
            end
            CLEAR: begin
               blk_cnt    <= '0;
               tile_valid <= 1'b1;
               state      <= TILE;
            end
            TILE: begin
               if (tile_ack) begin
                  tile_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ACC_FEEDER_PERF_EN
   // Free-running, wrapping counters of WAIT occupancy and acknowledged tiles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_wait_cyc <= '0;
         perf_tiles    <= '0;
      end else begin
         if (state == WAIT) begin
            perf_wait_cyc <= perf_wait_cyc + 32'd1;
         end
         if ((state == TILE) && tile_ack) begin
            perf_tiles <= perf_tiles + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_acc_block_feeder.sv
// Directed bench for acc_block_feeder: a latency-modelled accumulator stub drives done and
// running sums; tile results, issue counts and issue order are checked against hand values.
module tb_acc_block_feeder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned K_W   = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [127:0]   in_blk = '0;
   logic [31:0]    in_a11, in_a12, in_a21, in_a22;
   logic [K_W-1:0] k_count = K_W'(1);
   logic [31:0]    acc_a11, acc_a12, acc_a21, acc_a22;
   logic           acc_start, acc_clear;
   logic           acc_done;
   logic [127:0]   acc_sum;
   logic [31:0]    acc_o11, acc_o12, acc_o21, acc_o22;
   logic           tile_valid;
   logic [31:0]    tile_c11, tile_c12, tile_c21, tile_c22;
   logic           tile_ack = 1'b0;
`ifdef ACC_FEEDER_PERF_EN
   logic [31:0]    perf_wait_cyc;
   logic [15:0]    perf_tiles;
`endif

   always #5 clk = ~clk;

   assign {in_a11, in_a12, in_a21, in_a22} = in_blk;
   assign {acc_o11, acc_o12, acc_o21, acc_o22} = acc_sum;
   wire [127:0] acc_blk  = {acc_a11, acc_a12, acc_a21, acc_a22};
   wire [127:0] tile_blk = {tile_c11, tile_c12, tile_c21, tile_c22};

   acc_block_feeder #(.DEPTH(DEPTH), .K_W(K_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a11(in_a11), .in_a12(in_a12), .in_a21(in_a21), .in_a22(in_a22),
      .k_count(k_count),
      .acc_a11(acc_a11), .acc_a12(acc_a12), .acc_a21(acc_a21), .acc_a22(acc_a22),
      .acc_start(acc_start), .acc_clear(acc_clear), .acc_done(acc_done),
      .acc_o11(acc_o11), .acc_o12(acc_o12), .acc_o21(acc_o21), .acc_o22(acc_o22),
      .tile_valid(tile_valid),
      .tile_c11(tile_c11), .tile_c12(tile_c12), .tile_c21(tile_c21), .tile_c22(tile_c22),
      .tile_ack(tile_ack)
`ifdef ACC_FEEDER_PERF_EN
      , .perf_wait_cyc(perf_wait_cyc), .perf_tiles(perf_tiles)
`endif
   );

   // Accumulator stub: done 3 cycles after start; first sum after clear equals the block (0+x),
   // later sums come from sum_q (precomputed FP32 results or tokens).
   logic         model_done = 1'b0;
   logic         spur_done = 1'b0;
   logic         hold_done = 1'b0;
   logic         busy;
   logic         fresh;
   logic [127:0] held;
   int           lat_cnt;
   int           n_starts = 0;
   int           n_clears = 0;
   int           n_unstable = 0;
   int           n_overlap = 0;
   logic [127:0] issued[$];
   logic [127:0] sum_q[$];

   assign acc_done = model_done | spur_done;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_done <= 1'b0;
         busy       <= 1'b0;
         fresh      <= 1'b1;
         acc_sum    <= '0;
         held       <= '0;
         lat_cnt    <= 0;
      end else begin
         model_done <= 1'b0;
         if (acc_clear) begin
            acc_sum  <= '0;
            fresh    <= 1'b1;
            n_clears <= n_clears + 1;
         end
         if (acc_start) begin
            if (busy) n_overlap <= n_overlap + 1;
            n_starts <= n_starts + 1;
            issued.push_back(acc_blk);
            held    <= acc_blk;
            busy    <= 1'b1;
            lat_cnt <= 3;
         end else if (busy && !hold_done) begin
            if (lat_cnt <= 1) begin
               if (acc_blk !== held) n_unstable <= n_unstable + 1;
               model_done <= 1'b1;
               busy       <= 1'b0;
               fresh      <= 1'b0;
               if (fresh) acc_sum <= held;
               else if (sum_q.size() > 0) acc_sum <= sum_q.pop_front();
            end else begin
               lat_cnt <= lat_cnt - 1;
            end
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_blk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Offer one block at a negedge; accepted at the next posedge where in_ready is high.
   task automatic push_blk(input logic [127:0] b, input int budget);
      int  i = 0;
      bit  ok = 1'b0;
      in_blk   = b;
      in_valid = 1'b1;
      while (!ok && i < budget) begin
         if (in_ready) ok = 1'b1;
         @(negedge clk);
         i++;
      end
      in_valid = 1'b0;
      if (!ok) check_int("push_accepted", 0, 1);
   endtask

   task automatic wait_tile(input int budget);
      int i = 0;
      while (!tile_valid && i < budget) begin
         @(negedge clk);
         i++;
      end
      check_int("tile_valid_rise", int'(tile_valid), 1);
   endtask

   task automatic ack_tile();
      tile_ack = 1'b1;
      @(negedge clk);
      tile_ack = 1'b0;
      check_int("tile_valid_after_ack", int'(tile_valid), 0);
   endtask

   typedef struct {
      logic [K_W-1:0] k;
      logic [127:0]   blk;
      logic [127:0]   exp_tile;
   } vec_t;

   vec_t vecs[3];

   localparam logic [127:0] X2  = {32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
   localparam logic [127:0] X2S = {32'h40000000, 32'h40800000, 32'h40c00000, 32'h41000000};

   initial begin
      int s0;
      int c0;
      logic [127:0] blks[6];
      logic [127:0] tok;

      vecs[0] = '{k: K_W'(1), blk: {32'h41f0f5c3, 32'h42ee999a, 32'h3ee66666, 32'h4158a3d7},
                  exp_tile: {32'h41f0f5c3, 32'h42ee999a, 32'h3ee66666, 32'h4158a3d7}};
      vecs[1] = '{k: K_W'(0), blk: {32'hbf800000, 32'h00000001, 32'h7f7fffff, 32'h80000000},
                  exp_tile: {32'hbf800000, 32'h00000001, 32'h7f7fffff, 32'h80000000}};
      vecs[2] = '{k: K_W'(1), blk: {32'hdeadbeef, 32'h12345678, 32'hffffffff, 32'h00000000},
                  exp_tile: {32'hdeadbeef, 32'h12345678, 32'hffffffff, 32'h00000000}};

      // Reset state
      cycles(2);
      check_int("rst_in_ready", int'(in_ready), 1);
      check_int("rst_acc_start", int'(acc_start), 0);
      check_int("rst_acc_clear", int'(acc_clear), 0);
      check_int("rst_tile_valid", int'(tile_valid), 0);
      check_blk("rst_acc_a", acc_blk, '0);
      check_blk("rst_tile_c", tile_blk, '0);
      reset = 1'b0;
      cycles(2);

      // Reset asserted while waiting for done
      k_count   = K_W'(2);
      hold_done = 1'b1;
      s0 = n_starts;
      push_blk({4{32'h11111111}}, 20);
      push_blk({4{32'h22222222}}, 20);
      cycles(3);
      check_int("wait_one_start", n_starts - s0, 1);
      reset = 1'b1;
      @(negedge clk);
      check_int("midrst_in_ready", int'(in_ready), 1);
      check_int("midrst_tile_valid", int'(tile_valid), 0);
      check_int("midrst_acc_start", int'(acc_start), 0);
      reset     = 1'b0;
      hold_done = 1'b0;
      s0 = n_starts;
      cycles(10);
      check_int("midrst_fifo_empty", n_starts - s0, 0);
      check_int("midrst_no_tile", int'(tile_valid), 0);

      // Spurious done in IDLE and spurious ack outside TILE
      k_count = K_W'(1);
      s0 = n_starts;
      c0 = n_clears;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      tile_ack  = 1'b1;
      @(negedge clk);
      tile_ack  = 1'b0;
      cycles(3);
      check_int("spur_no_start", n_starts - s0, 0);
      check_int("spur_no_clear", n_clears - c0, 0);
      check_int("spur_no_tile", int'(tile_valid), 0);

      // Single-block tiles, bit-exact passthrough, k_count=0 as 1
      for (int i = 0; i < 3; i++) begin
         k_count = vecs[i].k;
         s0 = n_starts;
         push_blk(vecs[i].blk, 20);
         wait_tile(100);
         check_blk($sformatf("vec%0d_tile", i), tile_blk, vecs[i].exp_tile);
         check_int($sformatf("vec%0d_starts", i), n_starts - s0, 1);
         ack_tile();
      end

      // Two-block tile: X + X
      k_count = K_W'(2);
      sum_q.push_back(X2S);
      s0 = n_starts;
      c0 = n_clears;
      push_blk(X2, 20);
      push_blk(X2, 20);
      wait_tile(200);
      check_blk("k2_tile", tile_blk, X2S);
      check_int("k2_starts", n_starts - s0, 2);
      check_int("k2_clears", n_clears - c0, 1);
      cycles(5);
      check_int("k2_tile_held", int'(tile_valid), 1);
      check_blk("k2_tile_stable", tile_blk, X2S);
      ack_tile();

      // FIFO full: one block in flight plus DEPTH stored, sixth stalls until a pop
      k_count   = K_W'(6);
      hold_done = 1'b1;
      issued.delete();
      for (int i = 0; i < 6; i++) blks[i] = {4{32'ha0000000 | 32'(i)}};
      for (int i = 1; i <= 5; i++) begin
         tok = {4{32'hc0000000 | 32'(i)}};
         sum_q.push_back(tok);
      end
      s0 = n_starts;
      for (int i = 0; i < 5; i++) push_blk(blks[i], 20);
      cycles(2);
      check_int("full_in_ready", int'(in_ready), 0);
      check_int("full_one_start", n_starts - s0, 1);
      in_blk   = blks[5];
      in_valid = 1'b1;
      cycles(10);
      check_int("full_stall", int'(in_ready), 0);
      hold_done = 1'b0;
      push_blk(blks[5], 50);
      wait_tile(500);
      check_blk("full_tile", tile_blk, {4{32'hc0000005}});
      check_int("full_issued_cnt", issued.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < issued.size()) check_blk($sformatf("order%0d", i), issued[i], blks[i]);
      end
      ack_tile();
      check_int("full_drained_ready", int'(in_ready), 1);

      // Held tile blocks further issue until acknowledged
      k_count = K_W'(1);
      push_blk({4{32'h0000aaaa}}, 20);
      wait_tile(100);
      s0 = n_starts;
      push_blk({4{32'h0000bbbb}}, 20);
      push_blk({4{32'h0000cccc}}, 20);
      cycles(20);
      check_int("hold_no_start", n_starts - s0, 0);
      check_int("hold_tile_valid", int'(tile_valid), 1);
      check_blk("hold_tile_a", tile_blk, {4{32'h0000aaaa}});
      ack_tile();
      wait_tile(100);
      check_blk("hold_tile_b", tile_blk, {4{32'h0000bbbb}});
      ack_tile();
      wait_tile(100);
      check_blk("hold_tile_c", tile_blk, {4{32'h0000cccc}});
      ack_tile();
      check_int("hold_resume_starts", n_starts - s0, 2);

      check_int("acc_a_stable", n_unstable, 0);
      check_int("no_start_overlap", n_overlap, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
